// File: rtl/if_fetch_queue_pkg.sv
// Shared constants and helpers for the instruction fetch queue slice.
package if_fetch_queue_pkg;

    localparam int unsigned DEFAULT_XLEN          = 32;
    localparam logic [31:0] DEFAULT_PC_RESET_ADDR = 32'h0000_0000;
    localparam int unsigned INSTR_BYTES           = 4;
    localparam logic [31:0] NOP_INSTR             = 32'h0000_0013;

    // A request may issue only if an in-flight slot is free and a queue slot can be reserved for its response.
    function automatic logic issue_allowed(
        input int unsigned fq_count,
        input int unsigned outstanding,
        input int unsigned drop_cnt,
        input int unsigned fq_depth,
        input int unsigned max_outstanding
    );
        return (outstanding < max_outstanding) &&
               ((fq_count + outstanding - drop_cnt) < fq_depth);
    endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch unit bus bundle: redirect input, imem request/response channels and decode output.
interface if_fetch_queue_if
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned XLEN = DEFAULT_XLEN
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
        output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
        input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
    );

endinterface

// File: rtl/if_fetch_queue_fetch_sync_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO is accepted only alongside a pop.
module fetch_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s, do_pop_s;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        if (ptr == AW'(DEPTH - 1)) begin
            return {AW{1'b0}};
        end else begin
            return ptr + AW'(1);
        end
    endfunction

    assign empty_o   = (count_q == {CW{1'b0}});
    assign full_o    = (count_q == CW'(DEPTH));
    assign count_o   = count_q;
    assign data_o    = mem_q[rd_ptr_q];
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);

    // Pointer and occupancy next-state; flush discards everything including this cycle's push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written at the tail.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch unit: owns the fetch PC, issues imem requests, queues responses for decode
// and drops stale in-flight responses after a redirect.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned     XLEN            = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] PC_RESET_ADDR   = XLEN'(DEFAULT_PC_RESET_ADDR),
    parameter int unsigned     FQ_DEPTH        = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input logic              clk,
    input logic              rst_n,
    if_fetch_queue_if.master bus
);
    localparam int unsigned FQ_CW = $clog2(FQ_DEPTH + 1);
    localparam int unsigned OS_CW = $clog2(MAX_OUTSTANDING + 1);

    logic [XLEN-1:0]   pc_q, pc_d;
    logic [OS_CW-1:0]  drop_cnt_q, drop_cnt_d;
    logic [FQ_CW-1:0]  fq_count_s;
    logic              fq_full_s, fq_empty_s;
    logic [2*XLEN-1:0] fq_head_s;
    logic [OS_CW-1:0]  outstanding_s;
    logic              ifl_full_s, ifl_empty_s;
    logic [XLEN-1:0]   rsp_pc_s;
    logic              req_valid_s, req_acc_s, out_acc_s, fq_push_s;
    logic              unused_s;

    assign req_valid_s = rst_n && !bus.redirect_valid &&
                         issue_allowed(32'(fq_count_s), 32'(outstanding_s), 32'(drop_cnt_q),
                                       FQ_DEPTH, MAX_OUTSTANDING);
    assign req_acc_s   = req_valid_s && bus.imem_req_ready;
    assign out_acc_s   = bus.out_valid && bus.out_ready && !bus.redirect_valid;
    assign fq_push_s   = bus.imem_rsp_valid && !bus.redirect_valid &&
                         (drop_cnt_q == {OS_CW{1'b0}});

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = pc_q;
    assign bus.out_valid      = rst_n && !fq_empty_s;
    assign bus.out_pc         = fq_head_s[2*XLEN-1:XLEN];
    assign bus.out_instr      = fq_empty_s ? XLEN'(NOP_INSTR) : fq_head_s[XLEN-1:0];
    assign unused_s           = fq_full_s ^ ifl_full_s ^ ifl_empty_s;

    // Fetch PC and stale-response count; a redirect retargets and counts what is still in flight.
    always_comb begin
        pc_d       = pc_q;
        drop_cnt_d = drop_cnt_q;
        if (bus.redirect_valid) begin
            pc_d       = {bus.redirect_pc[XLEN-1:2], 2'b00};
            drop_cnt_d = outstanding_s - OS_CW'(bus.imem_rsp_valid);
        end else begin
            if (req_acc_s) begin
                pc_d = pc_q + XLEN'(INSTR_BYTES);
            end else begin
                pc_d = pc_q;
            end
            if (bus.imem_rsp_valid && (drop_cnt_q != {OS_CW{1'b0}})) begin
                drop_cnt_d = drop_cnt_q - OS_CW'(1);
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end
    end

    // Fetch state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= PC_RESET_ADDR;
            drop_cnt_q <= {OS_CW{1'b0}};
        end else begin
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // PCs of accepted requests, popped in order as responses arrive.
    fetch_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_inflight_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (1'b0),
        .push_i  (req_acc_s),
        .data_i  (pc_q),
        .pop_i   (bus.imem_rsp_valid),
        .data_o  (rsp_pc_s),
        .count_o (outstanding_s),
        .full_o  (ifl_full_s),
        .empty_o (ifl_empty_s)
    );

    fetch_sync_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (bus.redirect_valid),
        .push_i  (fq_push_s),
        .data_i  ({rsp_pc_s, bus.imem_rsp_data}),
        .pop_i   (out_acc_s),
        .data_o  (fq_head_s),
        .count_o (fq_count_s),
        .full_o  (fq_full_s),
        .empty_o (fq_empty_s)
    );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue: imem model with variable latency and a stream-level
// reference that predicts every request address and every delivered {pc, instr}.
module tb_if_fetch_queue;

    localparam int MAX_OS = 2;
    localparam int FQD    = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    if_fetch_queue_if #(.XLEN(32)) bus ();

    if_fetch_queue #(
        .XLEN            (32),
        .PC_RESET_ADDR   (32'h0000_0000),
        .FQ_DEPTH        (FQD),
        .MAX_OUTSTANDING (MAX_OS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          lat_min = 1, lat_max = 1, req_pct = 100, out_pct = 100;
    int          accepts = 0, delivers = 0, live = 0;
    logic [31:0] exp_req_pc = 32'h0, exp_out_pc = 32'h0, last_out_pc = 32'h0;
    logic        prev_req_stall = 1'b0, prev_out_stall = 1'b0;
    logic [31:0] prev_req_addr = 32'h0, prev_out_pc = 32'h0, prev_out_instr = 32'h0;
    logic        saw_out_valid = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle; called at a falling edge, returns at the next one.
    task automatic cycle(input logic redir, input logic [31:0] rpc);
        logic req_acc, out_acc;
        int   lat;
        int   os_before;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.imem_req_ready = ($urandom_range(99) < req_pct);
        bus.out_ready      = ($urandom_range(99) < out_pct);
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(pend_q[0].addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom();
        end
        #1;
        if (prev_req_stall && !redir) begin
            check_eq("req_hold_valid", bus.imem_req_valid, 1);
            check_eq("req_hold_addr", bus.imem_req_addr, prev_req_addr);
        end
        if (redir) check_eq("req_low_on_redirect", bus.imem_req_valid, 0);
        if (prev_out_stall) begin
            check_eq("out_hold_valid", bus.out_valid, 1);
            check_eq("out_hold_pc", bus.out_pc, prev_out_pc);
            check_eq("out_hold_instr", bus.out_instr, prev_out_instr);
        end
        req_acc       = bus.imem_req_valid && bus.imem_req_ready;
        out_acc       = bus.out_valid && bus.out_ready && !redir;
        saw_out_valid = bus.out_valid;
        os_before     = pend_q.size();
        if (bus.imem_rsp_valid) void'(pend_q.pop_front());
        if (req_acc) begin
            check_eq("req_addr", bus.imem_req_addr, exp_req_pc);
            check_eq("req_outstanding_bound", os_before < MAX_OS, 1);
            check_eq("req_slot_reserved", live < FQD, 1);
            lat = $urandom_range(lat_max, lat_min);
            pend_q.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
            exp_req_pc = exp_req_pc + 32'd4;
            accepts++;
            live++;
        end
        if (out_acc) begin
            check_eq("out_pc", bus.out_pc, exp_out_pc);
            check_eq("out_instr", bus.out_instr, mem_word(exp_out_pc));
            last_out_pc = bus.out_pc;
            exp_out_pc  = exp_out_pc + 32'd4;
            delivers++;
            live--;
        end
        if (redir) begin
            exp_req_pc = {rpc[31:2], 2'b00};
            exp_out_pc = {rpc[31:2], 2'b00};
            live       = 0;
        end
        prev_req_stall = bus.imem_req_valid && !bus.imem_req_ready;
        prev_req_addr  = bus.imem_req_addr;
        prev_out_stall = bus.out_valid && !bus.out_ready && !redir;
        prev_out_pc    = bus.out_pc;
        prev_out_instr = bus.out_instr;
        cyc++;
        @(negedge clk);
    endtask

    task automatic expect_next_out(input string tag, input logic [31:0] exp_pc);
        int d0 = delivers;
        int n  = 0;
        while (delivers == d0 && n < 60) begin
            cycle(1'b0, 32'h0);
            n++;
        end
        if (delivers == d0) check_eq({tag, "_timeout"}, 0, 1);
        else                check_eq(tag, last_out_pc, exp_pc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int          d0;
        int          n;
        logic [31:0] held;
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.out_ready      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_eq("reset_req_valid", bus.imem_req_valid, 0);
            check_eq("reset_out_valid", bus.out_valid, 0);
        end
        rst_n = 1'b1;

        // Decode stalled: queue fills to depth, head held, requests stop.
        out_pct = 0;
        repeat (10) cycle(1'b0, 32'h0);
        check_eq("stall_accepts", accepts, FQD);
        check_eq("stall_buffered", live, FQD);
        check_eq("stall_req_low", bus.imem_req_valid, 0);
        check_eq("stall_out_valid", bus.out_valid, 1);
        check_eq("stall_head_pc", bus.out_pc, 32'h0);

        // Release: drain 0x0..0xC, resume at 0x10, one instruction per cycle.
        out_pct = 100;
        d0 = delivers;
        repeat (20) cycle(1'b0, 32'h0);
        check_eq("throughput", delivers - d0, 20);
        check_eq("throughput_last_pc", last_out_pc, 32'h4C);

        // Latency 3, redirect with two requests in flight.
        lat_min = 3; lat_max = 3;
        n = 0;
        while (pend_q.size() != 2 && n < 20) begin
            cycle(1'b0, 32'h0);
            n++;
        end
        cycle(1'b1, 32'h0000_0103);
        expect_next_out("redir_first_pc", 32'h100);

        // Redirect coinciding with a response and a decode accept.
        lat_min = 1; lat_max = 1;
        repeat (6) cycle(1'b0, 32'h0);
        cycle(1'b1, 32'h0000_0300);
        check_eq("coincide_out_valid", saw_out_valid, 1);
        expect_next_out("coincide_first_pc", 32'h300);

        // imem not ready for 5 cycles: request held, then one accept advances by 4.
        req_pct = 0;
        repeat (5) cycle(1'b0, 32'h0);
        held = bus.imem_req_addr;
        check_eq("reqstall_valid", bus.imem_req_valid, 1);
        req_pct = 100;
        cycle(1'b0, 32'h0);
        check_eq("reqstall_advance", bus.imem_req_addr, held + 32'd4);

        // PC wrap and back-to-back redirects.
        cycle(1'b1, 32'hFFFF_FFFC);
        expect_next_out("wrap_first", 32'hFFFF_FFFC);
        expect_next_out("wrap_second", 32'h0000_0000);
        cycle(1'b1, 32'h0000_0040);
        cycle(1'b1, 32'h0000_0080);
        expect_next_out("b2b_first", 32'h80);

        // Random traffic.
        lat_min = 1; lat_max = 4; req_pct = 70; out_pct = 60;
        repeat (1500) cycle($urandom_range(99) < 3, $urandom());

        req_pct = 100; out_pct = 100;
        cycle(1'b1, 32'h0000_1000);
        expect_next_out("final_first_pc", 32'h1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
